// File: rtl/rr_stream_mux.sv
// Round-robin / fixed-priority N:1 stream multiplexer with a single registered output slot.
// state    | meaning
// ST_EMPTY | output slot holds no beat, out_valid=0
// ST_FULL  | output slot holds a beat, out_valid=1
module rr_stream_mux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int MODE  = 0,
    parameter int CW    = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_ch
);

    localparam logic [0:0]    ST_EMPTY = 1'b0;
    localparam logic [0:0]    ST_FULL  = 1'b1;
    localparam logic [CW:0]   NCH_W    = (CW+1)'(NCH);
    localparam logic [CW-1:0] LAST_CH  = CW'(NCH - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    ch_q, ch_d;
    logic [CW-1:0]    ptr_q, ptr_d;

    logic [WIDTH-1:0] in_arr [NCH];
    logic [CW:0]      cand;
    logic [CW-1:0]    grant_idx;
    logic             grant_vld;
    logic             loadable;
    logic             push;

    for (genvar k = 0; k < NCH; k++) begin : g_unpack
        assign in_arr[k] = in_data[k*WIDTH +: WIDTH];
    end

    // Search starts at the pointer and wraps; in fixed-priority mode the pointer stays 0.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = {1'b0, ptr_q} + (CW+1)'(i);
            if (cand >= NCH_W) cand = cand - NCH_W;
            if (!grant_vld && in_valid[cand[CW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[CW-1:0];
            end
        end
    end

    always_comb begin
        loadable = rst_n && ((state_q == ST_EMPTY) || out_ready);
        push     = loadable && grant_vld;
        in_ready = '0;
        if (push) in_ready[grant_idx] = 1'b1;

        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (push) begin
            state_d = ST_FULL;
            data_d  = in_arr[grant_idx];
            ch_d    = grant_idx;
            if (MODE == 0) ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + CW'(1);
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_ch    = ch_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: directed vector table, fixed-priority sequence and random
// traffic, with both arbitration modes checked against a queue-free slot/pointer model.
module tb_rr_stream_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic        out_ready;

    logic [3:0] in_ready_m  [2];
    logic [7:0] out_data_m  [2];
    logic       out_valid_m [2];
    logic [1:0] out_ch_m    [2];

    int checks   = 0;
    int failures = 0;

    // Reference model: one slot and one pointer per mode.
    bit       m_valid [2];
    bit [7:0] m_data  [2];
    int       m_ch    [2];
    int       m_ptr   [2];

    always #5 clk = ~clk;

    rr_stream_mux #(.WIDTH(8), .NCH(4), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m[0]), .out_data(out_data_m[0]), .out_valid(out_valid_m[0]),
        .out_ready(out_ready), .out_ch(out_ch_m[0])
    );

    rr_stream_mux #(.WIDTH(8), .NCH(4), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m[1]), .out_data(out_data_m[1]), .out_valid(out_valid_m[1]),
        .out_ready(out_ready), .out_ch(out_ch_m[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int m, input logic [3:0] v);
        if (v == 4'b0) return -1;
        if (m == 1) begin
            for (int c = 0; c < 4; c++) if (v[c]) return c;
        end
        for (int i = 0; i < 4; i++) begin
            int c = (m_ptr[m] + i) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Inputs already driven; checks both DUTs against the model, then crosses one edge.
    task automatic step();
        int g [2];
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            g[m] = (rst_n && (!m_valid[m] || out_ready)) ? pick(m, in_valid) : -1;
            chk($sformatf("model_in_ready_m%0d", m), 32'(in_ready_m[m]),
                (g[m] >= 0) ? (32'd1 << g[m]) : 32'd0);
            chk($sformatf("model_out_valid_m%0d", m), 32'(out_valid_m[m]), 32'(m_valid[m]));
            if (m_valid[m]) begin
                chk($sformatf("model_out_data_m%0d", m), 32'(out_data_m[m]), 32'(m_data[m]));
                chk($sformatf("model_out_ch_m%0d", m), 32'(out_ch_m[m]), 32'(m_ch[m]));
            end
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                m_valid[m] = 1'b0; m_data[m] = 8'h00; m_ch[m] = 0; m_ptr[m] = 0;
            end else if (g[m] >= 0) begin
                m_valid[m] = 1'b1;
                m_data[m]  = in_data[g[m]*8 +: 8];
                m_ch[m]    = g[m];
                if (m == 0) m_ptr[m] = (g[m] + 1) % 4;
            end else if (m_valid[m] && out_ready) begin
                m_valid[m] = 1'b0;
            end
        end
        #1;
    endtask

    typedef struct {
        bit        rst_n;
        bit [3:0]  valid;
        bit [31:0] data;
        bit        ordy;
        bit [3:0]  exp_rdy;
        bit        exp_ov;
        bit        chk_data;
        bit [1:0]  exp_ch;
        bit [7:0]  exp_od;
    } vec_t;

    vec_t vecs [19];

    initial begin
        // rst, valid, data, ordy | in_ready during, out_valid/check/ch/data after the edge (MODE 0)
        vecs[0]  = '{1'b0, 4'b1111, 32'hFFFFFFFF, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h00};
        vecs[1]  = '{1'b1, 4'b0100, 32'h44A52211, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 8'hA5};
        vecs[2]  = '{1'b1, 4'b1001, 32'h3C000077, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 8'h3C};
        vecs[3]  = '{1'b1, 4'b1001, 32'h3C000077, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h77};
        vecs[4]  = '{1'b1, 4'b1111, 32'hD3D2D1D0, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'hD1};
        vecs[5]  = '{1'b1, 4'b1111, 32'hD3D2D1D0, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 8'hD2};
        vecs[6]  = '{1'b1, 4'b1111, 32'hD3D2D1D0, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 8'hD3};
        vecs[7]  = '{1'b1, 4'b1111, 32'hD3D2D1D0, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 8'hD0};
        for (int i = 8; i <= 12; i++)
            vecs[i] = '{1'b1, 4'b1111, 32'hE3E2E1E0, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 8'hD0};
        vecs[13] = '{1'b1, 4'b1111, 32'hD3D2D1D0, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'hD1};
        vecs[14] = '{1'b1, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};
        vecs[15] = '{1'b1, 4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};
        vecs[16] = '{1'b1, 4'b0100, 32'h003C0000, 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h3C};
        vecs[17] = '{1'b0, 4'b1111, 32'h55555555, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h00};
        vecs[18] = '{1'b1, 4'b1010, 32'hBB00AA00, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'hAA};

        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 1'b0; m_data[m] = 8'h00; m_ch[m] = 0; m_ptr[m] = 0;
        end
        rst_n = 1'b0; in_valid = 4'b0; in_data = 32'h0; out_ready = 1'b0;
        #1;

        for (int i = 0; i < 19; i++) begin
            rst_n = vecs[i].rst_n; in_valid = vecs[i].valid;
            in_data = vecs[i].data; out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready_m[0]), 32'(vecs[i].exp_rdy));
            step();
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid_m[0]), 32'(vecs[i].exp_ov));
            if (vecs[i].chk_data) begin
                chk($sformatf("vec%0d_out_ch", i), 32'(out_ch_m[0]), 32'(vecs[i].exp_ch));
                chk($sformatf("vec%0d_out_data", i), 32'(out_data_m[0]), 32'(vecs[i].exp_od));
            end
        end

        // Fixed priority: lowest index always wins, then 1010 selects ch1.
        rst_n = 1'b0; step();
        rst_n = 1'b1; in_valid = 4'b1111; in_data = 32'h13121110; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("prio_ch_%0d", i), 32'(out_ch_m[1]), 32'd0);
            chk($sformatf("prio_data_%0d", i), 32'(out_data_m[1]), 32'h10);
        end
        in_valid = 4'b1010;
        step();
        chk("prio_1010_ch", 32'(out_ch_m[1]), 32'd1);
        chk("prio_1010_data", 32'(out_data_m[1]), 32'h11);

        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
